// File: rtl/quad_encoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_array
//  Description : Multi-channel quadrature encoder interface. Each channel has
//                debounce filters on A/B/Z, x1/x2/x4 decoding, index latch or
//                index-zero handling, a sticky invalid-transition flag and a
//                signed, saturating velocity. One shared sample timer sets the
//                velocity update rate for all channels.
//  Ports       : clk, rst_n (sync, active-low)
//                enc_a/enc_b/enc_z [NUM_CH]   raw encoder inputs (pre-synced)
//                enable/clear [NUM_CH]        per-channel enable / clear
//                decode_mode[2], index_mode[2] shared mode selects
//                position/index_pos [NUM_CH*COUNT_W], velocity [NUM_CH*VEL_W]
//                index_valid/direction/error [NUM_CH], sample_strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_array #(
    parameter int NUM_CH        = 2,
    parameter int COUNT_W       = 32,
    parameter int VEL_W         = 16,
    parameter int FILTER_LEN    = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           enc_a,
    input  logic [NUM_CH-1:0]           enc_b,
    input  logic [NUM_CH-1:0]           enc_z,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH-1:0]           clear,
    input  logic [1:0]                  decode_mode,
    input  logic [1:0]                  index_mode,
    output logic [NUM_CH*COUNT_W-1:0]   position,
    output logic [NUM_CH*VEL_W-1:0]     velocity,
    output logic [NUM_CH*COUNT_W-1:0]   index_pos,
    output logic [NUM_CH-1:0]           index_valid,
    output logic [NUM_CH-1:0]           direction,
    output logic [NUM_CH-1:0]           error,
    output logic                        sample_strobe
);

    localparam int C_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int C_TW = $clog2(SAMPLE_PERIOD);
    localparam logic [C_FW-1:0] C_FLAST = C_FW'(FILTER_LEN - 1);
    localparam logic [C_TW-1:0] C_TLAST = C_TW'(SAMPLE_PERIOD - 1);

    // ------------------------------------------------------------------
    // Shared velocity sample timer
    // ------------------------------------------------------------------
    logic [C_TW-1:0] r_timer_q, w_timer_d;
    logic            r_strobe_q, w_strobe_d;
    logic            w_sample;

    always_comb begin
        w_sample   = (r_timer_q == C_TLAST);
        w_timer_d  = w_sample ? '0 : r_timer_q + 1'b1;
        w_strobe_d = w_sample;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer_q  <= '0;
            r_strobe_q <= 1'b0;
        end else begin
            r_timer_q  <= w_timer_d;
            r_strobe_q <= w_strobe_d;
        end
    end

    assign sample_strobe = r_strobe_q;

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // bit 0 = A, bit 1 = B, bit 2 = Z
        logic [2:0]         w_raw;
        logic [2:0]         r_filt_q, w_filt_d;
        logic [2:0]         r_prev_q;
        logic [C_FW-1:0]    r_run_q [3];
        logic [C_FW-1:0]    w_run_d [3];
        logic [1:0]         w_cur, w_prv;
        logic               w_up, w_dn, w_inval, w_index;
        logic [COUNT_W-1:0] r_pos_q, w_pos_d, r_ipos_q, w_ipos_d, r_snap_q, w_snap_d;
        logic [COUNT_W-1:0] w_delta;
        logic [VEL_W-1:0]   r_vel_q, w_vel_d, w_vel_sat;
        logic               r_dir_q, w_dir_d, r_err_q, w_err_d, r_ival_q, w_ival_d;

        assign w_raw = {enc_z[i], enc_b[i], enc_a[i]};

        // Filtered value flips after FILTER_LEN consecutive mismatching samples
        always_comb begin
            w_filt_d = r_filt_q;
            for (int j = 0; j < 3; j++) begin
                w_run_d[j] = '0;
                if (w_raw[j] != r_filt_q[j]) begin
                    if (r_run_q[j] == C_FLAST) begin
                        w_filt_d[j] = ~r_filt_q[j];
                    end else begin
                        w_run_d[j] = r_run_q[j] + 1'b1;
                    end
                end
            end
        end

        // Decode on the {A,B} pair; forward is 00->01->11->10->00
        always_comb begin
            w_cur   = {r_filt_q[0], r_filt_q[1]};
            w_prv   = {r_prev_q[0], r_prev_q[1]};
            w_inval = ((w_cur ^ w_prv) == 2'b11);
            w_index = enable[i] & r_filt_q[2] & ~r_prev_q[2];
            w_up    = 1'b0;
            w_dn    = 1'b0;
            case (decode_mode)
                2'b00: begin
                    w_up = (w_prv == 2'b01) && (w_cur == 2'b11);
                    w_dn = (w_prv == 2'b11) && (w_cur == 2'b01);
                end
                2'b01: begin
                    w_up = ((w_prv == 2'b01) && (w_cur == 2'b11)) ||
                           ((w_prv == 2'b10) && (w_cur == 2'b00));
                    w_dn = ((w_prv == 2'b11) && (w_cur == 2'b01)) ||
                           ((w_prv == 2'b00) && (w_cur == 2'b10));
                end
                default: begin
                    w_up = ((w_prv == 2'b00) && (w_cur == 2'b01)) ||
                           ((w_prv == 2'b01) && (w_cur == 2'b11)) ||
                           ((w_prv == 2'b11) && (w_cur == 2'b10)) ||
                           ((w_prv == 2'b10) && (w_cur == 2'b00));
                    w_dn = ((w_prv == 2'b01) && (w_cur == 2'b00)) ||
                           ((w_prv == 2'b11) && (w_cur == 2'b01)) ||
                           ((w_prv == 2'b10) && (w_cur == 2'b11)) ||
                           ((w_prv == 2'b00) && (w_cur == 2'b10));
                end
            endcase
        end

        // Modular difference reinterpreted as signed, then clamped to VEL_W
        assign w_delta = r_pos_q - r_snap_q;

        if (VEL_W < COUNT_W) begin : g_sat
            localparam logic [COUNT_W-1:0] C_VMAX =
                {{(COUNT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
            localparam logic [COUNT_W-1:0] C_VMIN =
                {{(COUNT_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};
            always_comb begin
                if ($signed(w_delta) > $signed(C_VMAX)) begin
                    w_vel_sat = {1'b0, {(VEL_W-1){1'b1}}};
                end else if ($signed(w_delta) < $signed(C_VMIN)) begin
                    w_vel_sat = {1'b1, {(VEL_W-1){1'b0}}};
                end else begin
                    w_vel_sat = w_delta[VEL_W-1:0];
                end
            end
        end else begin : g_ext
            assign w_vel_sat = VEL_W'($signed(w_delta));
        end

        // Later assignments take priority: clear > index-zero > count
        always_comb begin
            w_pos_d  = r_pos_q;
            w_dir_d  = r_dir_q;
            w_err_d  = r_err_q;
            w_ipos_d = r_ipos_q;
            w_ival_d = r_ival_q;
            w_snap_d = r_snap_q;
            w_vel_d  = r_vel_q;
            if (w_inval) begin
                w_err_d = 1'b1;
            end
            if (enable[i]) begin
                if (w_up) begin
                    w_pos_d = r_pos_q + 1'b1;
                    w_dir_d = 1'b1;
                end else if (w_dn) begin
                    w_pos_d = r_pos_q - 1'b1;
                    w_dir_d = 1'b0;
                end
            end
            if (w_index) begin
                if (index_mode == 2'b01) begin
                    w_ipos_d = r_pos_q;
                    w_ival_d = 1'b1;
                end else if (index_mode == 2'b10) begin
                    w_pos_d  = '0;
                    w_dir_d  = r_dir_q;
                    w_ipos_d = r_pos_q;
                    w_ival_d = 1'b1;
                end
            end
            if (w_sample) begin
                w_snap_d = r_pos_q;
                w_vel_d  = w_vel_sat;
            end
            if (clear[i]) begin
                w_pos_d  = '0;
                w_err_d  = 1'b0;
                w_ipos_d = '0;
                w_ival_d = 1'b0;
                w_snap_d = '0;
                w_vel_d  = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_filt_q <= '0;
                r_prev_q <= '0;
                for (int j = 0; j < 3; j++) begin
                    r_run_q[j] <= '0;
                end
                r_pos_q  <= '0;
                r_dir_q  <= 1'b0;
                r_err_q  <= 1'b0;
                r_ipos_q <= '0;
                r_ival_q <= 1'b0;
                r_snap_q <= '0;
                r_vel_q  <= '0;
            end else begin
                r_filt_q <= w_filt_d;
                r_prev_q <= r_filt_q;
                for (int j = 0; j < 3; j++) begin
                    r_run_q[j] <= w_run_d[j];
                end
                r_pos_q  <= w_pos_d;
                r_dir_q  <= w_dir_d;
                r_err_q  <= w_err_d;
                r_ipos_q <= w_ipos_d;
                r_ival_q <= w_ival_d;
                r_snap_q <= w_snap_d;
                r_vel_q  <= w_vel_d;
            end
        end

        assign position[i*COUNT_W +: COUNT_W]  = r_pos_q;
        assign index_pos[i*COUNT_W +: COUNT_W] = r_ipos_q;
        assign velocity[i*VEL_W +: VEL_W]      = r_vel_q;
        assign index_valid[i]                  = r_ival_q;
        assign direction[i]                    = r_dir_q;
        assign error[i]                        = r_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_array
//  Description : Directed self-checking bench. Main instance uses default
//                parameters (FILTER_LEN=4, VEL_W=16); a second instance with
//                FILTER_LEN=1 and VEL_W=8 exercises velocity saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_array;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  enc_a, enc_b, enc_z, enable, clear;
    logic [1:0]  decode_mode, index_mode;
    logic [63:0] position, index_pos;
    logic [31:0] velocity;
    logic [1:0]  index_valid, direction, error;
    logic        sample_strobe;

    logic [1:0]  a_s, b_s, z_s, clear_s;
    logic [63:0] position_s, index_pos_s;
    logic [15:0] velocity_s;
    logic [1:0]  index_valid_s, direction_s, error_s;
    logic        sample_strobe_s;

    int checks   = 0;
    int failures = 0;
    logic [1:0] s0, s2;

    quad_encoder_array u_dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .enable(enable), .clear(clear), .decode_mode(decode_mode),
        .index_mode(index_mode), .position(position), .velocity(velocity),
        .index_pos(index_pos), .index_valid(index_valid), .direction(direction),
        .error(error), .sample_strobe(sample_strobe)
    );

    quad_encoder_array #(.VEL_W(8), .FILTER_LEN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enc_a(a_s), .enc_b(b_s), .enc_z(z_s),
        .enable(2'b11), .clear(clear_s), .decode_mode(decode_mode),
        .index_mode(index_mode), .position(position_s), .velocity(velocity_s),
        .index_pos(index_pos_s), .index_valid(index_valid_s),
        .direction(direction_s), .error(error_s), .sample_strobe(sample_strobe_s)
    );

    function automatic logic [1:0] nxt(input logic [1:0] s, input bit fwd);
        logic [1:0] r;
        if (fwd) begin
            case (s)
                2'b00: r = 2'b01;
                2'b01: r = 2'b11;
                2'b11: r = 2'b10;
                default: r = 2'b00;
            endcase
        end else begin
            case (s)
                2'b00: r = 2'b10;
                2'b10: r = 2'b11;
                2'b11: r = 2'b01;
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step0(input bit fwd, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            s0 = nxt(s0, fwd);
            enc_a[0] = s0[1];
            enc_b[0] = s0[0];
            tick(gap);
        end
    endtask

    task automatic step_s(input bit fwd, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            s2 = nxt(s2, fwd);
            a_s[0] = s2[1];
            b_s[0] = s2[0];
            tick(gap);
        end
    endtask

    task automatic wait_strobe();
        int k = 0;
        while (sample_strobe !== 1'b1 && k < 1100) begin
            tick(1);
            k++;
        end
        chk("strobe_seen", {63'd0, sample_strobe}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; enc_a = '0; enc_b = '0; enc_z = '0; enable = '0; clear = '0;
        decode_mode = 2'b10; index_mode = 2'b00;
        a_s = '0; b_s = '0; z_s = '0; clear_s = '0;
        s0 = 2'b00; s2 = 2'b00;
        tick(3);
        chk("rst_position", position, 64'd0);
        chk("rst_velocity", {32'd0, velocity}, 64'd0);
        chk("rst_index", {index_pos[31:0], 30'd0, index_valid}, 64'd0);
        chk("rst_flags", {58'd0, direction, error, 1'b0, sample_strobe}, 64'd0);
        rst_n = 1'b1;
        enable = 2'b11;

        // x4 counting
        step0(1'b1, 8, 10);
        chk("x4_fwd_pos", {32'd0, position[31:0]}, 64'd8);
        chk("x4_fwd_dir_err", {62'd0, direction[0], error[0]}, 64'b10);
        step0(1'b0, 3, 10);
        chk("x4_rev_pos", {32'd0, position[31:0]}, 64'd5);
        chk("x4_rev_dir", {63'd0, direction[0]}, 64'd0);

        clear = 2'b01; tick(1); clear = 2'b00;
        chk("clear_pos", {32'd0, position[31:0]}, 64'd0);

        // x1 then x2
        decode_mode = 2'b00;
        step0(1'b1, 4, 10);
        chk("x1_fwd", {32'd0, position[31:0]}, 64'd1);
        step0(1'b0, 4, 10);
        chk("x1_rev", {32'd0, position[31:0]}, 64'd0);
        decode_mode = 2'b01;
        step0(1'b1, 4, 10);
        chk("x2_fwd", {32'd0, position[31:0]}, 64'd2);
        step0(1'b0, 4, 10);
        chk("x2_rev", {32'd0, position[31:0]}, 64'd0);

        // wrap below zero
        decode_mode = 2'b10;
        step0(1'b0, 1, 10);
        chk("wrap_pos", {32'd0, position[31:0]}, 64'hFFFF_FFFF);

        // 3-cycle glitch on A is rejected
        enc_a[0] = 1'b1; tick(3); enc_a[0] = 1'b0; tick(10);
        chk("glitch_pos", {32'd0, position[31:0]}, 64'hFFFF_FFFF);
        chk("glitch_err", {63'd0, error[0]}, 64'd0);

        // 00 -> 11 jump
        s0 = 2'b11; enc_a[0] = 1'b1; enc_b[0] = 1'b1; tick(10);
        chk("jump_err", {63'd0, error[0]}, 64'd1);
        chk("jump_pos", {32'd0, position[31:0]}, 64'hFFFF_FFFF);
        clear = 2'b01; tick(1); clear = 2'b00;
        chk("clear_err_pos", {31'd0, error[0], position[31:0]}, 64'd0);

        // index latch
        step0(1'b1, 37, 10);
        index_mode = 2'b01; enc_z[0] = 1'b1; tick(10);
        chk("idx_latch_pos", {32'd0, index_pos[31:0]}, 64'd37);
        chk("idx_latch_valid", {63'd0, index_valid[0]}, 64'd1);
        step0(1'b1, 2, 10);
        chk("idx_latch_count", {index_pos[31:0], position[31:0]}, {32'd37, 32'd39});
        enc_z[0] = 1'b0; tick(10);

        // index zero: exact filter + decode latency
        index_mode = 2'b10; enc_z[0] = 1'b1;
        tick(4);
        chk("idx_zero_before", {32'd0, position[31:0]}, 64'd39);
        tick(1);
        chk("idx_zero_pos", {32'd0, position[31:0]}, 64'd0);
        chk("idx_zero_ipos", {32'd0, index_pos[31:0]}, 64'd39);
        enc_z[0] = 1'b0; index_mode = 2'b00; tick(10);

        // enable low ignores a step; re-enable adds nothing
        enable = 2'b10;
        step0(1'b1, 1, 10);
        chk("disabled_step", {32'd0, position[31:0]}, 64'd0);
        enable = 2'b11; tick(10);
        chk("reenable_pos", {32'd0, position[31:0]}, 64'd0);
        step0(1'b1, 1, 10);
        chk("after_reenable", {32'd0, position[31:0]}, 64'd1);

        chk("ch1_untouched", {position[63:32], 29'd0, index_valid[1], error[1], direction[1]}, 64'd0);

        // velocity +50 / -50
        wait_strobe();
        step0(1'b1, 50, 8);
        wait_strobe();
        chk("vel_plus50", {48'd0, velocity[15:0]}, 64'd50);
        chk("vel_ch1", {48'd0, velocity[31:16]}, 64'd0);
        tick(1);
        chk("strobe_one_cycle", {63'd0, sample_strobe}, 64'd0);
        step0(1'b0, 50, 8);
        wait_strobe();
        chk("vel_minus50", {48'd0, velocity[15:0]}, 64'hFFCE);

        // saturation on the 8-bit instance
        step_s(1'b1, 200, 3);
        wait_strobe();
        chk("sat_pos", {32'd0, position_s[31:0]}, 64'd200);
        chk("sat_vel_pos", {56'd0, velocity_s[7:0]}, 64'h7F);
        chk("idle_vel", {48'd0, velocity[15:0]}, 64'd0);
        step_s(1'b0, 200, 3);
        wait_strobe();
        chk("sat_vel_neg", {56'd0, velocity_s[7:0]}, 64'h80);
        chk("sat_ch1", {48'd0, velocity_s[15:8], velocity[31:24]}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
